stream_2d_array_rows: RTL and testbench
=======================================

// Module: stream_2d_array_rows
// PURPOSE
//  Accepts a ROWS x COLS matrix of BIT_WIDTH elements over a valid/ready handshake, latches it,
//  and emits it one row per beat as a flattened COLS*BIT_WIDTH vector over a second valid/ready handshake.
//  Sits between matrix producers (unpacked 2D arrays) and narrow row-serial datapaths.
//  Flattened row layout, right to left: column 0, column 1, column 2, ...
// PARAMETERS
//  BIT_WIDTH  4  element width in bits
//  COLS       8  elements per row (output beat width = COLS*BIT_WIDTH)
//  ROWS       4  rows per matrix (beats per matrix); ROWS >= 1
// PORTS
//  clk        in   1                    single clock, rising edge
//  rst        in   1                    asynchronous, active-high reset
//  in_data    in   [BIT_WIDTH-1:0] x [ROWS-1:0][COLS-1:0]  unpacked matrix, in_data[r][c]
//  in_valid   in   1                    matrix valid
//  in_ready   out  1                    block can accept a matrix
//  out_data   out  COLS*BIT_WIDTH       current row; out_data[(c+1)*BIT_WIDTH-1 -: BIT_WIDTH] = row[c]
//  out_row    out  $clog2(ROWS) (min 1) index of current row
//  out_last   out  1                    high when out_row == ROWS-1
//  out_valid  out  1                    row beat valid
//  out_ready  in   1                    downstream accepts beat
// BEHAVIOUR
//  - Reset: state IDLE, row counter 0, out_valid 0, out_data 0, out_row 0, out_last 0; in_ready 1 once in IDLE.
//  - Reset asserted mid-matrix discards all held data; no partial beats after release.
//  - FSM: IDLE -> STREAM on in_valid & in_ready (matrix registered, row = 0).
//    STREAM: out_valid = 1; out_data/out_row/out_last driven from registered matrix and row counter.
//    Handshake (out_valid & out_ready): row++; on beat with out_last, return to IDLE or reload (see CONFIGURATION).
//  - Latency: first beat valid the cycle after input handshake. No combinational path in_* -> out_*.
//  - out_data, out_row, out_last stable while out_valid & !out_ready (AXI-style hold).
//  - in_ready must not depend on in_valid; out_valid must not depend on out_ready.
//  - ROWS == 1: every beat is last; row counter stays 0.
//  - Row counter never wraps past ROWS-1; it resets to 0 on the last beat.
// CONFIGURATION
//  Macro STREAM_2D_ARRAY_ROWS_DBUF_EN (double buffer):
//  - Undefined: in_ready = (state == IDLE). Input taken only in IDLE; ROWS+1 cycles/matrix minimum (one bubble).
//  - Defined: extra matrix holding buffer + buf_full flag. in_ready = !buf_full (also high during STREAM).
//    Input handshake during STREAM fills the buffer. On the last-beat handshake: if buf_full, buffer
//    moves into the active register, row = 0, stay STREAM, buf_full cleared (no bubble). If buffer empty and
//    in_valid & in_ready in the same cycle, the new matrix loads directly into the active register, stay STREAM.
//    Otherwise go to IDLE. Sustained throughput: ROWS cycles/matrix. Reset clears buf_full.
// STRUCTURE
//  - Package stream_2d_array_pkg: state enum typedef (IDLE, STREAM); function row_idx_w(ROWS) = max(1,$clog2(ROWS)).
//  - Sub-module row_flatten: combinational, selects in row r from registered matrix, packs column 0 at LSB.
//  - Top: FSM, row counter, matrix register(s), handshake logic.
// TESTING (BIT_WIDTH=4, COLS=2, ROWS=3 unless noted)
//  - Reset: hold rst with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 after release.
//  - Single matrix {{1,2},{3,4},{5,6}}, out_ready=1 -> beats 8'h21,8'h43,8'h65 on 3 consecutive cycles; out_last on 3rd.
//  - Backpressure: out_ready=0 for 5 cycles on row 1 -> 8'h43, out_row=1 held stable; resumes on out_ready=1.
//  - Back-to-back matrices, out_ready=1: without DBUF 4 cycles/matrix, one idle cycle; with DBUF 3 cycles, zero gaps.
//  - Reset asserted on row 1 -> out_valid=0 next cycle; next matrix starts at row 0 with no stale data.
//  - ROWS=1, COLS=8: every beat has out_last=1, out_row=0, full 32-bit row packed column 0 at LSB.

Source files
------------

// File: rtl/stream_2d_array_pkg.sv
// ----------------------------------------------------------------------------
// stream_2d_array_pkg
// Shared types and helpers for the stream_2d_array_rows matrix-to-row
// serialiser.
//   state_t   : FSM state encoding (IDLE, STREAM)
//   row_idx_w : width of the row index, never less than one bit
// ----------------------------------------------------------------------------
package stream_2d_array_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // ROWS == 1 still needs a one-bit row port.
   function automatic int row_idx_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/stream_2d_array_rows_row_flatten.sv
// ----------------------------------------------------------------------------
// row_flatten
// Purely combinational row selector.  It picks row i_row out of the
// registered matrix and packs it into one flat word, with column 0 in the
// least significant bits.
// Ports:
//   i_mat  : matrix, i_mat[r][c]
//   i_row  : row to select
//   o_data : packed row, o_data[(c+1)*BIT_WIDTH-1 -: BIT_WIDTH] = i_mat[i_row][c]
// ----------------------------------------------------------------------------
module row_flatten
   import stream_2d_array_pkg::*;
#(
   parameter int BIT_WIDTH = 4,
   parameter int COLS      = 8,
   parameter int ROWS      = 4
) (
   input  logic [BIT_WIDTH-1:0]        i_mat [ROWS-1:0][COLS-1:0],
   input  logic [row_idx_w(ROWS)-1:0]  i_row,
   output logic [COLS*BIT_WIDTH-1:0]   o_data
);

   localparam int RW = row_idx_w(ROWS);

   // A compare-per-row mux keeps the index in range when ROWS is not a
   // power of two.
   always_comb begin
      o_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (i_row == RW'(r)) begin
            for (int c = 0; c < COLS; c++) begin
               o_data[c*BIT_WIDTH +: BIT_WIDTH] = i_mat[r][c];
            end
         end
      end
   end

endmodule

// File: rtl/stream_2d_array_rows.sv
// ----------------------------------------------------------------------------
// stream_2d_array_rows
// Accepts a whole ROWS x COLS matrix in one valid/ready handshake. It latches
// the matrix and then sends it out one row per beat over a second valid/ready
// handshake.
//
// Optional feature macro: STREAM_2D_ARRAY_ROWS_DBUF_EN
//   When defined, a second matrix buffer lets the next matrix be accepted
//   while the current one is streaming.  This removes the idle cycle between
//   matrices.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_data   : input matrix, in_data[r][c]
//   in_valid  : matrix valid
//   in_ready  : block can take a matrix
//   out_data  : current row, column 0 at LSB (zero when no beat is valid)
//   out_row   : index of the current row
//   out_last  : current beat is the last row
//   out_valid : row beat valid
//   out_ready : downstream accepts the beat
// ----------------------------------------------------------------------------
module stream_2d_array_rows
   import stream_2d_array_pkg::*;
#(
   parameter int BIT_WIDTH = 4,
   parameter int COLS      = 8,
   parameter int ROWS      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BIT_WIDTH-1:0]        in_data [ROWS-1:0][COLS-1:0],
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [COLS*BIT_WIDTH-1:0]   out_data,
   output logic [row_idx_w(ROWS)-1:0]  out_row,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int            RW       = row_idx_w(ROWS);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [RW-1:0]            r_row;
   logic [RW-1:0]            w_row_nxt;
   logic [BIT_WIDTH-1:0]     r_mat [ROWS-1:0][COLS-1:0];
   logic                     w_load_act;
   logic                     w_is_last;
   logic [COLS*BIT_WIDTH-1:0] w_row_data;

`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
   logic [BIT_WIDTH-1:0]     r_buf [ROWS-1:0][COLS-1:0];
   logic                     r_buf_full;
   logic                     w_buf_full_nxt;
   logic                     w_load_buf;
   logic                     w_from_buf;
`endif

   assign w_is_last = (r_row == ROW_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, handshake outputs and register load strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_load_act  = 1'b0;
      out_valid   = (r_state == STREAM);
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
      in_ready       = !r_buf_full;
      w_buf_full_nxt = r_buf_full;
      w_load_buf     = 1'b0;
      w_from_buf     = 1'b0;
`else
      in_ready       = (r_state == IDLE);
`endif

      case (r_state)
         IDLE: begin
            if (in_valid && in_ready) begin
               w_state_nxt = STREAM;
               w_load_act  = 1'b1;
               w_row_nxt   = '0;
            end
         end
         STREAM: begin
            if (out_ready && w_is_last) begin
               w_row_nxt   = '0;
               w_state_nxt = IDLE;
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
               // Refill the active register with no bubble: a buffered
               // matrix takes priority over the input port.  in_ready is
               // low while the buffer is full, so both cannot occur at once.
               if (r_buf_full) begin
                  w_from_buf     = 1'b1;
                  w_buf_full_nxt = 1'b0;
                  w_state_nxt    = STREAM;
               end else if (in_valid) begin
                  w_load_act  = 1'b1;
                  w_state_nxt = STREAM;
               end
`endif
            end else begin
               if (out_ready) begin
                  w_row_nxt = r_row + RW'(1);
               end
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
               if (in_valid && in_ready) begin
                  w_load_buf     = 1'b1;
                  w_buf_full_nxt = 1'b1;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Row counter (and buffer-full flag) are control and are reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= '0;
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
         r_buf_full <= 1'b0;
`endif
      end else begin
         r_row <= w_row_nxt;
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
         r_buf_full <= w_buf_full_nxt;
`endif
      end
   end

   // The matrix storage is not reset.  Stale contents are never visible,
   // because the outputs are gated by the STREAM state.
   always_ff @(posedge clk) begin
      if (w_load_act) begin
         r_mat <= in_data;
      end
`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
      else if (w_from_buf) begin
         r_mat <= r_buf;
      end
      if (w_load_buf) begin
         r_buf <= in_data;
      end
`endif
   end

   row_flatten #(
      .BIT_WIDTH (BIT_WIDTH),
      .COLS      (COLS),
      .ROWS      (ROWS)
   ) u_row_flatten (
      .i_mat  (r_mat),
      .i_row  (r_row),
      .o_data (w_row_data)
   );

   assign out_data = out_valid ? w_row_data : '0;
   assign out_row  = r_row;
   assign out_last = out_valid && w_is_last;

endmodule

// File: tb/tb_stream_2d_array_rows.sv
module tb_stream_2d_array_rows;

   typedef logic [3:0] mat3_t [2:0][1:0];
   typedef logic [3:0] mat1_t [0:0][7:0];
   typedef logic [7:0] exp3_t [3];

   typedef struct {
      logic [31:0] d;
      logic [1:0]  row;
      logic        last;
   } beat_t;

`ifdef STREAM_2D_ARRAY_ROWS_DBUF_EN
   localparam int MAT_PERIOD = 3;
`else
   localparam int MAT_PERIOD = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   // DUT0: BIT_WIDTH=4, COLS=2, ROWS=3
   logic [3:0]  in_data [2:0][1:0];
   logic        in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0]  out_data;
   logic [1:0]  out_row;
   // DUT1: BIT_WIDTH=4, COLS=8, ROWS=1
   logic [3:0]  in_data1 [0:0][7:0];
   logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
   logic [31:0] out_data1;
   logic [0:0]  out_row1;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   beat_t sb0[$];
   beat_t sb1[$];
   int    cyc_q[$];
   beat_t e0, e1;

   stream_2d_array_rows #(.BIT_WIDTH(4), .COLS(2), .ROWS(3)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_row(out_row), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_2d_array_rows #(.BIT_WIDTH(4), .COLS(8), .ROWS(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_data(out_data1), .out_row(out_row1), .out_last(out_last1),
      .out_valid(out_valid1), .out_ready(out_ready1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: compare every accepted beat with the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb0.size() == 0) begin
            chk("dut0 unexpected beat", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            e0 = sb0.pop_front();
            chk("dut0 data", 32'(out_data), e0.d);
            chk("dut0 row",  32'(out_row),  32'(e0.row));
            chk("dut0 last", 32'(out_last), 32'(e0.last));
         end
         cyc_q.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         if (sb1.size() == 0) begin
            chk("dut1 unexpected beat", out_data1, ~out_data1);
         end else begin
            e1 = sb1.pop_front();
            chk("dut1 data", out_data1,        e1.d);
            chk("dut1 row",  32'(out_row1),    32'(e1.row));
            chk("dut1 last", 32'(out_last1),   32'(e1.last));
         end
      end
   end

   function automatic mat3_t mk3(input logic [3:0] a0, a1, b0, b1, c0, c1);
      mat3_t m;
      m[0][0] = a0; m[0][1] = a1;
      m[1][0] = b0; m[1][1] = b1;
      m[2][0] = c0; m[2][1] = c1;
      return m;
   endfunction

   function automatic mat1_t mk1(input logic [3:0] c0, c1, c2, c3, c4, c5, c6, c7);
      mat1_t m;
      m[0][0] = c0; m[0][1] = c1; m[0][2] = c2; m[0][3] = c3;
      m[0][4] = c4; m[0][5] = c5; m[0][6] = c6; m[0][7] = c7;
      return m;
   endfunction

   // Called just after a rising edge; returns just after the handshake edge.
   task automatic send0(input mat3_t m, input exp3_t ex, output int hs_cyc);
      int n = 0;
      beat_t b;
      in_data  = m;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      hs_cyc = cyc;
      if (!in_ready) begin
         chk("dut0 in_ready timeout", 32'(in_ready), 32'h1);
      end else begin
         for (int r = 0; r < 3; r++) begin
            b.d    = 32'(ex[r]);
            b.row  = 2'(r);
            b.last = (r == 2);
            sb0.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send1(input mat1_t m, input logic [31:0] ex);
      int n = 0;
      beat_t b;
      in_data1  = m;
      in_valid1 = 1'b1;
      @(negedge clk);
      while (!in_ready1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready1) begin
         chk("dut1 in_ready timeout", 32'(in_ready1), 32'h1);
      end else begin
         b.d = ex; b.row = 2'd0; b.last = 1'b1;
         sb1.push_back(b);
      end
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb0.size() != 0 || sb1.size() != 0) && n < 60) begin
         @(posedge clk);
         n++;
      end
      chk(name, 32'(sb0.size() + sb1.size()), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs;
      int c0;
      int hs_b;
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_valid1  = 1'b1;
      in_data    = mk3(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
      in_data1   = mk1(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9);
      out_ready  = 1'b1;
      out_ready1 = 1'b1;

      // Reset held with in_valid asserted.
      repeat (3) @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk("rst out_data",  32'(out_data),  32'h0);
      chk("rst out_row",   32'(out_row),   32'h0);
      chk("rst out_last",  32'(out_last),  32'h0);
      chk("rst dut1 out_valid", 32'(out_valid1), 32'h0);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready",  32'(in_ready),  32'h1);
      chk("post-rst out_valid", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;

      // Single matrix, no backpressure.
      cyc_q.delete();
      send0(mk3(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6), '{8'h21, 8'h43, 8'h65}, hs);
      drain("single drain");
      chk("single beat count", 32'(cyc_q.size()), 32'd3);
      if (cyc_q.size() == 3) begin
         chk("single first latency", 32'(cyc_q[0] - hs), 32'd1);
         chk("single beat2 spacing", 32'(cyc_q[1] - cyc_q[0]), 32'd1);
         chk("single beat3 spacing", 32'(cyc_q[2] - cyc_q[1]), 32'd1);
      end

      // Backpressure held on row 1.
      out_ready = 1'b0;
      send0(mk3(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6), '{8'h21, 8'h43, 8'h65}, hs);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp out_valid", 32'(out_valid), 32'h1);
         chk("bp out_data",  32'(out_data),  32'h43);
         chk("bp out_row",   32'(out_row),   32'h1);
         chk("bp out_last",  32'(out_last),  32'h0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("bp drain");

      // Back-to-back matrices.
      cyc_q.delete();
      send0(mk3(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6), '{8'h21, 8'h43, 8'h65}, hs);
      send0(mk3(4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC), '{8'h87, 8'hA9, 8'hCB}, hs_b);
      drain("b2b drain");
      chk("b2b beat count", 32'(cyc_q.size()), 32'd6);
      if (cyc_q.size() == 6) begin
         chk("b2b matrix period", 32'(cyc_q[3] - cyc_q[0]), 32'(MAT_PERIOD));
         chk("b2b inter-matrix gap", 32'(cyc_q[3] - cyc_q[2]), 32'(MAT_PERIOD - 2));
         chk("b2b 2nd matrix spacing", 32'(cyc_q[5] - cyc_q[3]), 32'd2);
      end

      // Reset on row 1 discards the matrix.
      out_ready = 1'b0;
      send0(mk3(4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC), '{8'h87, 8'hA9, 8'hCB}, hs);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst out_valid", 32'(out_valid), 32'h0);
      chk("midrst out_data",  32'(out_data),  32'h0);
      chk("midrst out_row",   32'(out_row),   32'h0);
      sb0.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst no stale beat", 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send0(mk3(4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2), '{8'hED, 8'h0F, 8'h21}, hs);
      drain("after-rst drain");

      // ROWS=1, COLS=8 instance: every beat last, row 0.
      send1(mk1(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8), 32'h8765_4321);
      send1(mk1(4'hF, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0), 32'h0123_456F);
      drain("rows1 drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
